// File: rtl/instr_decode_queue.sv
// Instruction queue plus decode stage feeding the register file read/write ports.
// Optional HAZARD_STALL_EN: holds back a FIFO head that reads a just-issued destination.
module instr_decode_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Instr_In,
    input  logic              Instr_Valid,
    output logic              Instr_Ready,
    input  logic              Flush,
    output logic [ADDR_W-1:0] Read_Register_1,
    output logic [ADDR_W-1:0] Read_Register_2,
    output logic [ADDR_W-1:0] Write_Register,
    output logic [DATA_W-1:0] Imm_Out,
    output logic [5:0]        Opcode_Out,
    output logic              Sig_Reg_Write,
    output logic              Sig_Illegal,
    output logic              Dec_Valid,
    input  logic              Dec_Ready
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    logic              dec_valid_q, dec_valid_d;
    logic [ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, wr_q, wr_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [5:0]        op_q, op_d;
    logic              we_q, we_d, ill_q, ill_d;

    logic              enq, deq, stall;
    logic [DATA_W-1:0] head;
    logic [5:0]        head_op;
    logic [ADDR_W-1:0] head_rs, head_rt, head_rd, dec_wr;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_we, dec_ill;

    assign Instr_Ready = (count_q != CntW'(DEPTH));
    assign enq         = Instr_Valid && Instr_Ready;
    assign deq         = (count_q != '0) && (!dec_valid_q || Dec_Ready) && !stall;
    assign head        = mem_q[rd_ptr_q];

    // Combinational decode of the FIFO head; registered only when it moves out.
    always_comb begin
        head_op = head[31:26];
        head_rs = ADDR_W'(head[25:21]);
        head_rt = ADDR_W'(head[20:16]);
        head_rd = ADDR_W'(head[15:11]);
        dec_imm = {{(DATA_W-16){head[15]}}, head[15:0]};
        dec_wr  = '0;
        dec_we  = 1'b0;
        dec_ill = 1'b0;
        case (head_op)
            6'h00: begin
                dec_wr = head_rd;
                dec_we = 1'b1;
            end
            6'h08, 6'h23: begin
                dec_wr = head_rt;
                dec_we = 1'b1;
            end
            6'h2B, 6'h04: begin
                dec_wr = '0;
                dec_we = 1'b0;
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_wr == '0) dec_we = 1'b0;
    end

`ifdef HAZARD_STALL_EN
    logic [ADDR_W-1:0] sb_rd_q, sb_rd_d;
    logic              sb_live_q, sb_live_d;
    logic              handoff, hit_now, hit_sb;

    assign handoff = dec_valid_q && Dec_Ready;

    // Window covers the hand-off cycle itself (live compare) and the one after (scoreboard).
    always_comb begin
        hit_now   = handoff && we_q && (head_rs == wr_q || head_rt == wr_q);
        hit_sb    = sb_live_q && (sb_rd_q != '0) && (head_rs == sb_rd_q || head_rt == sb_rd_q);
        stall     = hit_now || hit_sb;
        sb_rd_d   = sb_rd_q;
        sb_live_d = 1'b0;
        if (Flush) begin
            sb_rd_d = '0;
        end else if (handoff) begin
            sb_rd_d   = we_q ? wr_q : '0;
            sb_live_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sb_rd_q   <= '0;
            sb_live_q <= 1'b0;
        end else begin
            sb_rd_q   <= sb_rd_d;
            sb_live_q <= sb_live_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dec_valid_d = dec_valid_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        wr_d        = wr_q;
        imm_d       = imm_q;
        op_d        = op_q;
        we_d        = we_q;
        ill_d       = ill_q;
        if (Flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            dec_valid_d = 1'b0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
            if (deq) begin
                dec_valid_d = 1'b1;
                rs_d        = head_rs;
                rt_d        = head_rt;
                wr_d        = dec_wr;
                imm_d       = dec_imm;
                op_d        = head_op;
                we_d        = dec_we;
                ill_d       = dec_ill;
            end else if (Dec_Ready) begin
                dec_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (enq && !Flush) mem_q[wr_ptr_q] <= Instr_In;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dec_valid_q <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            wr_q        <= '0;
            imm_q       <= '0;
            op_q        <= '0;
            we_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dec_valid_q <= dec_valid_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            wr_q        <= wr_d;
            imm_q       <= imm_d;
            op_q        <= op_d;
            we_q        <= we_d;
            ill_q       <= ill_d;
        end
    end

    assign Dec_Valid       = dec_valid_q;
    assign Read_Register_1 = rs_q;
    assign Read_Register_2 = rt_q;
    assign Write_Register  = wr_q;
    assign Imm_Out         = imm_q;
    assign Opcode_Out      = op_q;
    assign Sig_Reg_Write   = we_q;
    assign Sig_Illegal     = ill_q;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue: directed timing cases plus randomized traffic.
module tb_instr_decode_queue;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Instr_In;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic        Flush;
    logic [4:0]  Read_Register_1, Read_Register_2, Write_Register;
    logic [31:0] Imm_Out;
    logic [5:0]  Opcode_Out;
    logic        Sig_Reg_Write, Sig_Illegal, Dec_Valid, Dec_Ready;

    always #5 Clk = ~Clk;

    instr_decode_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Instr_In        (Instr_In),
        .Instr_Valid     (Instr_Valid),
        .Instr_Ready     (Instr_Ready),
        .Flush           (Flush),
        .Read_Register_1 (Read_Register_1),
        .Read_Register_2 (Read_Register_2),
        .Write_Register  (Write_Register),
        .Imm_Out         (Imm_Out),
        .Opcode_Out      (Opcode_Out),
        .Sig_Reg_Write   (Sig_Reg_Write),
        .Sig_Illegal     (Sig_Illegal),
        .Dec_Valid       (Dec_Valid),
        .Dec_Ready       (Dec_Ready)
    );

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [31:0] imm;
        logic [5:0]  op;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_popped = 0;

    localparam logic [31:0] AddR1 = 32'h0043_0820;  // add r1,r2,r3
    localparam logic [31:0] AddR4 = 32'h0025_2020;  // add r4,r1,r5

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected decode straight from the ISA field rules.
    function automatic exp_t model(input logic [31:0] w);
        exp_t        e;
        int unsigned op, rs, rt, rd, lo, dest;
        logic [31:0] imm;
        op   = w >> 26;
        rs   = (w >> 21) & 31;
        rt   = (w >> 16) & 31;
        rd   = (w >> 11) & 31;
        lo   = w & 32'hFFFF;
        imm  = lo;
        if (lo >= 32'h8000) imm = lo - 32'h1_0000;
        dest = 0;
        if (op == 0) dest = rd;
        else if (op == 8 || op == 35) dest = rt;
        e.rs  = 5'(rs);
        e.rt  = 5'(rt);
        e.wr  = 5'(dest);
        e.imm = imm;
        e.op  = 6'(op);
        e.we  = (dest != 0);
        e.ill = !(op == 0 || op == 8 || op == 35 || op == 43 || op == 4);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  ops [6];
        ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h23;
        ops[3] = 6'h2B; ops[4] = 6'h04; ops[5] = 6'($urandom_range(0, 63));
        w        = $urandom;
        w[31:26] = ops[$urandom_range(0, 5)];
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        w[15:11] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    // Monitor: samples on the falling edge, pops on hand-off, pushes on accept.
    initial begin
        logic        hold_prev;
        logic [22:0] snap_f;
        logic [31:0] snap_imm;
        exp_t        e;
        hold_prev = 1'b0;
        snap_f    = '0;
        snap_imm  = '0;
        forever begin
            @(negedge Clk);
            if (Reset || Flush) begin
                exp_q.delete();
                hold_prev = 1'b0;
            end else begin
                if (hold_prev && Dec_Valid) begin
                    check("hold_fields", 32'({Read_Register_1, Read_Register_2, Write_Register,
                                              Opcode_Out, Sig_Reg_Write, Sig_Illegal}),
                          32'(snap_f));
                    check("hold_imm", Imm_Out, snap_imm);
                end
                if (Dec_Valid && Dec_Ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got opcode 0x%02h, required none at %0t",
                                 Opcode_Out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        n_popped++;
                        check("sb_rs", 32'(Read_Register_1), 32'(e.rs));
                        check("sb_rt", 32'(Read_Register_2), 32'(e.rt));
                        check("sb_wr", 32'(Write_Register), 32'(e.wr));
                        check("sb_imm", Imm_Out, e.imm);
                        check("sb_op", 32'(Opcode_Out), 32'(e.op));
                        check("sb_we", 32'(Sig_Reg_Write), 32'(e.we));
                        check("sb_ill", 32'(Sig_Illegal), 32'(e.ill));
                    end
                end
                if (Instr_Valid && Instr_Ready) exp_q.push_back(model(Instr_In));
                hold_prev = Dec_Valid && !Dec_Ready;
                snap_f    = {Read_Register_1, Read_Register_2, Write_Register,
                             Opcode_Out, Sig_Reg_Write, Sig_Illegal};
                snap_imm  = Imm_Out;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || Dec_Valid) && n < 100) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        logic [31:0] bp [5];
        logic [31:0] mix [6];
        int          gap, pops0;

        Reset = 1'b1; Instr_In = '0; Instr_Valid = 1'b0; Flush = 1'b0; Dec_Ready = 1'b0;
        repeat (2) tick();
        Reset = 1'b0;
        tick();
        check("rst_dec_valid", 32'(Dec_Valid), 32'd0);
        check("rst_instr_ready", 32'(Instr_Ready), 32'd1);
        check("rst_outputs", {Read_Register_1, Read_Register_2, Write_Register, Opcode_Out,
                              Sig_Reg_Write, Sig_Illegal, 9'd0}, 32'd0);
        check("rst_imm", Imm_Out, 32'd0);

        // First-instruction latency.
        Dec_Ready = 1'b1; Instr_In = AddR1; Instr_Valid = 1'b1;
        tick();
        Instr_Valid = 1'b0;
        check("lat_edge_n", 32'(Dec_Valid), 32'd0);
        tick();
        check("lat_edge_n1", 32'(Dec_Valid), 32'd1);
        check("lat_rs", 32'(Read_Register_1), 32'd2);
        check("lat_rt", 32'(Read_Register_2), 32'd3);
        check("lat_wr", 32'(Write_Register), 32'd1);
        check("lat_we", 32'(Sig_Reg_Write), 32'd1);
        wait_idle();

        // Assorted opcodes back to back.
        mix[0] = 32'h2001_FFFF; mix[1] = 32'hAC22_0004; mix[2] = 32'hFC00_0000;
        mix[3] = 32'h0043_0020; mix[4] = 32'h1022_0003; mix[5] = 32'h8C41_0008;
        foreach (mix[i]) begin
            Instr_In = mix[i]; Instr_Valid = 1'b1;
            tick();
        end
        Instr_Valid = 1'b0;
        wait_idle();

        // Backpressure: four FIFO entries plus the output stage.
        bp[0] = AddR1;        bp[1] = 32'h2001_FFFF; bp[2] = 32'hAC22_0004;
        bp[3] = 32'h8C41_0008; bp[4] = 32'h1022_0003;
        Dec_Ready = 1'b0;
        foreach (bp[i]) begin
            check($sformatf("bp_ready_%0d", i), 32'(Instr_Ready), 32'd1);
            Instr_In = bp[i]; Instr_Valid = 1'b1;
            tick();
        end
        Instr_Valid = 1'b0;
        check("bp_full", 32'(Instr_Ready), 32'd0);
        check("bp_valid", 32'(Dec_Valid), 32'd1);
        pops0 = n_popped;
        Dec_Ready = 1'b1;
        wait_idle();
        check("bp_count", 32'(n_popped - pops0), 32'd5);

        // Flush with a simultaneous enqueue.
        Dec_Ready = 1'b0;
        repeat (4) begin
            Instr_In = rand_instr(); Instr_Valid = 1'b1;
            tick();
        end
        Flush = 1'b1; Instr_In = AddR1;
        tick();
        Flush = 1'b0; Instr_Valid = 1'b0;
        check("flush_valid", 32'(Dec_Valid), 32'd0);
        check("flush_ready", 32'(Instr_Ready), 32'd1);
        Dec_Ready = 1'b1;
        repeat (4) tick();
        check("flush_empty", 32'(Dec_Valid), 32'd0);
        wait_idle();

        // Dependent back-to-back pair.
        Instr_In = AddR1; Instr_Valid = 1'b1;
        tick();
        Instr_In = AddR4;
        tick();
        Instr_Valid = 1'b0;
        check("dep_first", 32'(Dec_Valid), 32'd1);
        gap = 0;
        for (int i = 1; i <= 10 && gap == 0; i++) begin
            tick();
            if (Dec_Valid) gap = i;
        end
`ifdef HAZARD_STALL_EN
        check("dep_gap", 32'(gap), 32'd3);
`else
        check("dep_gap", 32'(gap), 32'd1);
`endif
        wait_idle();

        // Randomized traffic with backpressure and occasional flushes.
        for (int c = 0; c < 400; c++) begin
            Instr_Valid = ($urandom_range(0, 9) < 6);
            Instr_In    = rand_instr();
            Dec_Ready   = ($urandom_range(0, 9) < 7);
            Flush       = ($urandom_range(0, 49) == 0);
            tick();
        end
        Instr_Valid = 1'b0; Flush = 1'b0; Dec_Ready = 1'b1;
        wait_idle();

        // Asynchronous reset between clock edges.
        Dec_Ready = 1'b0;
        repeat (2) begin
            Instr_In = AddR1; Instr_Valid = 1'b1;
            tick();
        end
        Instr_Valid = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(Dec_Valid), 32'd0);
        check("async_rst_we", 32'(Sig_Reg_Write), 32'd0);
        check("async_rst_ready", 32'(Instr_Ready), 32'd1);
        repeat (2) tick();
        Reset = 1'b0;
        Dec_Ready = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", 32'(Dec_Valid), 32'd0);
        Instr_In = 32'h2001_FFFF; Instr_Valid = 1'b1;
        tick();
        Instr_Valid = 1'b0;
        tick();
        check("post_rst_imm", Imm_Out, 32'hFFFF_FFFF);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
